// File: rtl/garage_door_sequencer_pkg.sv
// Shared types for the garage door sequencer: state codes, travel direction
// and a small helper for the motion states.
package garage_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        STOPPED = 3'd4,
        FAULT   = 3'd5
    } state_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic is_moving(input state_e s);
        return (s == OPENING) || (s == CLOSING);
    endfunction

endpackage

// File: rtl/garage_door_sequencer_req_edge_arb.sv
// Rising-edge detect on the request lines with a fixed lowest-index-wins pick.
// Losing same-cycle edges are dropped, not queued.
module req_edge_arb #(
    parameter int N_REQ = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    output logic             cmd_o,
    output logic [N_REQ-1:0] win_o
);

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] edg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end

    assign edg = req_i & ~req_q;

    // two's-complement trick isolates the lowest set bit
    assign win_o = edg & (~edg + 1'b1);
    assign cmd_o = |edg;

endmodule

// File: rtl/garage_door_sequencer.sv
// Garage door motor sequencer: command arbitration, travel FSM, obstruction
// reversal, travel timeout, auto-close and courtesy light.
module garage_door_sequencer
    import garage_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int CNT_W          = 16,
    parameter int TRAVEL_TMO_CYC = 5000,
    parameter int AUTO_CLOSE_CYC = 1000,
    parameter int LIGHT_HOLD_CYC = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] req_grant,
    input  logic             UP_max,
    input  logic             DN_max,
    input  logic             obstruct,
    input  logic             auto_close_en,
    output logic             UP_m,
    output logic             DN_m,
    output logic             light,
    output logic             fault,
    output logic [2:0]       state_o
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TRAVEL_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] AC_LAST  = CNT_W'(AUTO_CLOSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD     = CNT_W'(LIGHT_HOLD_CYC);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] lgt_q, lgt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             cmd;
    logic [N_REQ-1:0] win;
    logic             take;
    logic             tmo_hit;
    logic             both_lim;

    req_edge_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req),
        .cmd_o (cmd),
        .win_o (win)
    );

    assign tmo_hit  = (tmr_q == TMO_LAST);
    assign both_lim = UP_max & DN_max;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        take    = 1'b0;
        unique case (state_q)
            CLOSED: begin
                if (both_lim) begin
                    state_d = FAULT;
                end else if (cmd) begin
                    state_d = OPENING;
                    take    = 1'b1;
                end
            end
            OPENING: begin
                if (UP_max) begin
                    state_d = OPEN;
                end else if (tmo_hit) begin
                    state_d = FAULT;
                end else if (cmd) begin
                    state_d = STOPPED;
                    dir_d   = DIR_UP;
                    take    = 1'b1;
                end
            end
            OPEN: begin
                if (both_lim) begin
                    state_d = FAULT;
                end else if (cmd && !obstruct) begin
                    state_d = CLOSING;
                    take    = 1'b1;
                end else if (auto_close_en && tmr_q == AC_LAST
                             && !obstruct) begin
                    state_d = CLOSING;
                end
            end
            CLOSING: begin
                // limit beats obstruction: door is already down
                if (DN_max) begin
                    state_d = CLOSED;
                end else if (obstruct) begin
                    state_d = OPENING;
                end else if (tmo_hit) begin
                    state_d = FAULT;
                end else if (cmd) begin
                    state_d = STOPPED;
                    dir_d   = DIR_DOWN;
                    take    = 1'b1;
                end
            end
            STOPPED: begin
                if (cmd) begin
                    take = 1'b1;
                    if (dir_q == DIR_DOWN || obstruct) begin
                        state_d = OPENING;
                    end else begin
                        state_d = CLOSING;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_comb begin
        tmr_d = tmr_q;
        if (state_d != state_q || (state_q == OPEN && obstruct)) begin
            tmr_d = '0;
        end else if (!(&tmr_q)) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    // counter is parked at HOLD during motion so it runs down after exit
    always_comb begin
        lgt_d = lgt_q;
        if (is_moving(state_q)) begin
            lgt_d = HOLD;
        end else if (lgt_q != '0) begin
            lgt_d = lgt_q - 1'b1;
        end
    end

    assign grant_d = take ? win : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLOSED;
            dir_q   <= DIR_DOWN;
            tmr_q   <= '0;
            lgt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            lgt_q   <= lgt_d;
            grant_q <= grant_d;
        end
    end

    assign UP_m      = (state_q == OPENING);
    assign DN_m      = (state_q == CLOSING);
    assign fault     = (state_q == FAULT);
    assign light     = is_moving(state_q) || (state_q == FAULT)
                       || (lgt_q != '0);
    assign state_o   = state_q;
    assign req_grant = grant_q;

endmodule

// File: tb/tb_garage_door_sequencer.sv
// Directed scenarios plus randomized traffic, checked against a
// cycle-level behavioural model of the door sequencer.
module tb_garage_door_sequencer;

    localparam int TMO  = 50;
    localparam int AC   = 20;
    localparam int HOLD = 10;

    localparam int S_CLOSED  = 0;
    localparam int S_OPENING = 1;
    localparam int S_OPEN    = 2;
    localparam int S_CLOSING = 3;
    localparam int S_STOPPED = 4;
    localparam int S_FAULT   = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] req_grant;
    logic       UP_max, DN_max, obstruct, auto_close_en;
    logic       UP_m, DN_m, light, fault;
    logic [2:0] state_o;

    int ntests = 0;
    int nfail  = 0;

    int         m_st;
    bit         m_dir_up;
    logic [2:0] m_prev;
    int         m_time;
    bit         m_moved;
    int         m_since;
    logic [2:0] m_grant;

    garage_door_sequencer #(
        .N_REQ          (3),
        .CNT_W          (16),
        .TRAVEL_TMO_CYC (TMO),
        .AUTO_CLOSE_CYC (AC),
        .LIGHT_HOLD_CYC (HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_grant     (req_grant),
        .UP_max        (UP_max),
        .DN_max        (DN_max),
        .obstruct      (obstruct),
        .auto_close_en (auto_close_en),
        .UP_m          (UP_m),
        .DN_m          (DN_m),
        .light         (light),
        .fault         (fault),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    function automatic bit mov(input int s);
        return (s == S_OPENING) || (s == S_CLOSING);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st     = S_CLOSED;
        m_dir_up = 1'b0;
        m_prev   = '0;
        m_time   = 0;
        m_moved  = 1'b0;
        m_since  = 0;
        m_grant  = '0;
    endtask

    task automatic model_step();
        logic [2:0] e;
        int         w;
        int         nx;
        bit         cmd;
        bit         took;
        e = req & ~m_prev;
        w = -1;
        for (int i = 0; i < 3; i++) if (e[i] && w < 0) w = i;
        cmd  = (w >= 0);
        nx   = m_st;
        took = 1'b0;
        case (m_st)
            S_CLOSED:
                if (UP_max && DN_max) nx = S_FAULT;
                else if (cmd) begin nx = S_OPENING; took = 1'b1; end
            S_OPENING:
                if (UP_max) nx = S_OPEN;
                else if (m_time == TMO - 1) nx = S_FAULT;
                else if (cmd) begin
                    nx = S_STOPPED; m_dir_up = 1'b1; took = 1'b1;
                end
            S_OPEN:
                if (UP_max && DN_max) nx = S_FAULT;
                else if (cmd && !obstruct) begin
                    nx = S_CLOSING; took = 1'b1;
                end else if (auto_close_en && m_time == AC - 1 && !obstruct)
                    nx = S_CLOSING;
            S_CLOSING:
                if (DN_max) nx = S_CLOSED;
                else if (obstruct) nx = S_OPENING;
                else if (m_time == TMO - 1) nx = S_FAULT;
                else if (cmd) begin
                    nx = S_STOPPED; m_dir_up = 1'b0; took = 1'b1;
                end
            S_STOPPED:
                if (cmd) begin
                    took = 1'b1;
                    nx = (!m_dir_up || obstruct) ? S_OPENING : S_CLOSING;
                end
            default: ;
        endcase
        m_grant = took ? 3'(1 << w) : 3'b000;
        if (mov(nx)) m_moved = 1'b1;
        else if (mov(m_st)) m_since = 0;
        else m_since++;
        if (nx != m_st || (m_st == S_OPEN && obstruct)) m_time = 0;
        else if (m_time < 65535) m_time++;
        m_prev = req;
        m_st   = nx;
    endtask

    task automatic check_all(input string p);
        bit exp_light;
        exp_light = mov(m_st) || (m_st == S_FAULT)
                    || (m_moved && m_since < HOLD);
        chk({p, ".state"}, 8'(state_o), 8'(m_st));
        chk({p, ".up"}, 8'(UP_m), 8'(m_st == S_OPENING));
        chk({p, ".dn"}, 8'(DN_m), 8'(m_st == S_CLOSING));
        chk({p, ".fault"}, 8'(fault), 8'(m_st == S_FAULT));
        chk({p, ".light"}, 8'(light), 8'(exp_light));
        chk({p, ".grant"}, 8'(req_grant), 8'(m_grant));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all("mdl");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        model_reset();
        #1;
        check_all("rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b0;
        req = '0;
        UP_max = 1'b0;
        DN_max = 1'b0;
        obstruct = 1'b0;
        auto_close_en = 1'b0;
        model_reset();
        do_reset();
        chk("rst.state", 8'(state_o), 8'd0);
        chk("rst.light", 8'(light), 8'd0);

        // open, travel, reach top, light hold
        DN_max = 1'b1;
        tick();
        req = 3'b010;
        tick();
        chk("t1.grant", 8'(req_grant), 8'h02);
        chk("t1.up", 8'(UP_m), 8'd1);
        DN_max = 1'b0;
        repeat (28) tick();
        UP_max = 1'b1;
        tick();
        chk("t1.open", 8'(state_o), 8'd2);
        chk("t1.upoff", 8'(UP_m), 8'd0);
        repeat (9) tick();
        chk("t1.lighton", 8'(light), 8'd1);
        tick();
        chk("t1.lightoff", 8'(light), 8'd0);

        // same-cycle edges and held level
        req = 3'b000;
        UP_max = 1'b0;
        tick();
        req = 3'b110;
        tick();
        chk("t2.grant", 8'(req_grant), 8'h02);
        chk("t2.closing", 8'(state_o), 8'd3);
        tick();
        chk("t2.held", 8'(req_grant), 8'h00);

        // reversal, then obstruct with DN_max
        obstruct = 1'b1;
        tick();
        chk("t3.dn", 8'(DN_m), 8'd0);
        chk("t3.up", 8'(UP_m), 8'd1);
        obstruct = 1'b0;
        UP_max = 1'b1;
        tick();
        req = 3'b000;
        tick();
        req = 3'b001;
        tick();
        chk("t3.grant", 8'(req_grant), 8'h01);
        UP_max = 1'b0;
        DN_max = 1'b1;
        obstruct = 1'b1;
        tick();
        chk("t3.closed", 8'(state_o), 8'd0);

        // stop and resume
        obstruct = 1'b0;
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        DN_max = 1'b0;
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        chk("t4.stopped", 8'(state_o), 8'd4);
        chk("t4.motors", 8'({UP_m, DN_m}), 8'd0);
        chk("t4.grant", 8'(req_grant), 8'h04);
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        chk("t4.resdn", 8'(DN_m), 8'd1);
        obstruct = 1'b1;
        tick();
        obstruct = 1'b0;
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        chk("t4.stop2", 8'(state_o), 8'd4);
        obstruct = 1'b1;
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        chk("t4.resup", 8'(UP_m), 8'd1);
        obstruct = 1'b0;

        // auto-close with restart, then travel timeout
        UP_max = 1'b1;
        tick();
        auto_close_en = 1'b1;
        repeat (5) tick();
        obstruct = 1'b1;
        tick();
        obstruct = 1'b0;
        repeat (19) tick();
        chk("t5.stillopen", 8'(state_o), 8'd2);
        tick();
        chk("t5.autoclose", 8'(state_o), 8'd3);
        auto_close_en = 1'b0;
        UP_max = 1'b0;
        repeat (49) tick();
        chk("t5.notyet", 8'(state_o), 8'd3);
        tick();
        chk("t5.fault", 8'(fault), 8'd1);
        chk("t5.flight", 8'(light), 8'd1);
        req = 3'b000;
        tick();
        req = 3'b001;
        tick();
        chk("t5.stuck", 8'(state_o), 8'd5);
        do_reset();
        chk("t5.cleared", 8'(fault), 8'd0);

        // asynchronous reset mid-travel
        DN_max = 1'b1;
        tick();
        req = 3'b010;
        tick();
        DN_max = 1'b0;
        repeat (3) tick();
        chk("t6.moving", 8'(UP_m), 8'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6.upoff", 8'(UP_m), 8'd0);
        chk("t6.closed", 8'(state_o), 8'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) do_reset();
            r = $urandom;
            req = req ^ {r[0] & r[1] & r[2], r[3] & r[4] & r[5],
                         r[6] & r[7] & r[8]};
            UP_max = ($urandom_range(0, 7) == 0);
            DN_max = ($urandom_range(0, 7) == 0);
            obstruct = ($urandom_range(0, 9) == 0);
            auto_close_en = 1'($urandom_range(0, 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
